// File: rtl/regex_match_collector_if.sv
// Result channel between regex_match_collector and the host readout logic.
// The collector drives records through the master modport; the consumer uses slave.
interface regex_match_collector_if #(
   parameter int POS_W = 32
) ();
   logic             res_valid;
   logic             res_ready;
   logic [POS_W-1:0] res_start;
   logic [POS_W-1:0] res_end;
   logic             res_last;

   modport master (
      output res_valid,
      output res_start,
      output res_end,
      output res_last,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_start,
      input  res_end,
      input  res_last,
      output res_ready
   );
endinterface

// File: rtl/regex_match_collector.sv
// Captures each regex-core match once into a show-ahead FIFO and appends an end-of-stream marker.
// Optional duplicate-match suppression is enabled by defining REGEX_COLLECT_DEDUP_EN.
module regex_match_collector #(
   parameter int POS_W  = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rdy,
   input  logic                match,
   input  logic                last,
   input  logic [POS_W-1:0]    start_pos,
   input  logic [POS_W-1:0]    end_pos,
   regex_match_collector_if.master res_if,
   output logic [ADDR_W:0]     fifo_count,
   output logic [15:0]         overflow_cnt,
   output logic                done
);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   localparam int               REC_W  = 2 * POS_W + 1;
   localparam logic [ADDR_W:0]  FULL_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [POS_W-1:0] ONES_C = {POS_W{1'b1}};

   logic [REC_W-1:0]  mem_q [DEPTH];
   state_e            state_q, state_d;
   logic              rdy_q;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              pend_last_q, pend_last_d;
   logic [POS_W-1:0]  mark_start_q, mark_start_d, mark_end_q, mark_end_d;
   logic [15:0]       ovf_q, ovf_d;
   logic              valid_q, valid_d;
   logic [REC_W-1:0]  head_q, head_d;
   logic              done_q, done_d;

   logic              event_s, process_s, marker_evt_s, match_evt_s;
   logic              pop_s, space_s, push_s, dup_s;
   logic [REC_W-1:0]  wdata_s;
   logic [POS_W-1:0]  mk_start_s, mk_end_s;

   assign event_s      = rdy & ~rdy_q;
   assign process_s    = event_s & (state_q != ST_DRAIN);
   assign marker_evt_s = process_s & last;
   assign match_evt_s  = process_s & match & ~last;
   assign pop_s        = valid_q & res_if.res_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign space_s      = (count_q != FULL_C) | pop_s;
   assign mk_start_s   = match ? start_pos : ONES_C;
   assign mk_end_s     = match ? end_pos : ONES_C;

`ifdef REGEX_COLLECT_DEDUP_EN
   logic             hist_valid_q, hist_valid_d;
   logic [POS_W-1:0] hist_start_q, hist_start_d, hist_end_q, hist_end_d;
   logic             match_push_s;

   // History is ignored on the event that leaves DONE, since that event also clears it.
   assign dup_s        = hist_valid_q & (state_q != ST_DONE) &
                         (start_pos == hist_start_q) & (end_pos == hist_end_q);
   assign match_push_s = match_evt_s & ~dup_s & space_s;

   // Last pushed match positions.
   always_comb begin
      hist_valid_d = hist_valid_q;
      hist_start_d = hist_start_q;
      hist_end_d   = hist_end_q;
      if (match_push_s) begin
         hist_valid_d = 1'b1;
         hist_start_d = start_pos;
         hist_end_d   = end_pos;
      end else if ((state_q == ST_DONE) && event_s) begin
         hist_valid_d = 1'b0;
      end else begin
         hist_valid_d = hist_valid_q;
      end
   end

   // History registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_valid_q <= 1'b0;
         hist_start_q <= '0;
         hist_end_q   <= '0;
      end else begin
         hist_valid_q <= hist_valid_d;
         hist_start_q <= hist_start_d;
         hist_end_q   <= hist_end_d;
      end
   end
`else
   assign dup_s = 1'b0;
`endif

   // Push arbitration: a pending marker first, then a new marker, then a match.
   always_comb begin
      push_s       = 1'b0;
      wdata_s      = '0;
      pend_last_d  = pend_last_q;
      mark_start_d = mark_start_q;
      mark_end_d   = mark_end_q;
      ovf_d        = ovf_q;
      if (pend_last_q) begin
         if (space_s) begin
            push_s      = 1'b1;
            wdata_s     = {mark_start_q, mark_end_q, 1'b1};
            pend_last_d = 1'b0;
         end else begin
            pend_last_d = 1'b1;
         end
      end else if (marker_evt_s) begin
         if (space_s) begin
            push_s  = 1'b1;
            wdata_s = {mk_start_s, mk_end_s, 1'b1};
         end else begin
            pend_last_d  = 1'b1;
            mark_start_d = mk_start_s;
            mark_end_d   = mk_end_s;
         end
      end else if (match_evt_s && !dup_s) begin
         if (space_s) begin
            push_s  = 1'b1;
            wdata_s = {start_pos, end_pos, 1'b0};
         end else if (ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
         end else begin
            ovf_d = ovf_q;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // Pointers, occupancy and the registered show-ahead head.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      // The new head bypasses the array when it is the record written on this edge.
      if (count_d == '0) begin
         head_d = head_q;
      end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wdata_s;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COLLECT: begin
            if (marker_evt_s) state_d = ST_DRAIN;
            else              state_d = ST_COLLECT;
         end
         ST_DRAIN: begin
            if (pop_s && head_q[0]) state_d = ST_DONE;
            else                    state_d = ST_DRAIN;
         end
         ST_DONE: begin
            if (event_s) state_d = last ? ST_DRAIN : ST_COLLECT;
            else         state_d = ST_DONE;
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   // FSM outputs.
   always_comb begin
      done_d = (state_d == ST_DONE);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_COLLECT;
      else          state_q <= state_d;
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pend_last_q  <= 1'b0;
         mark_start_q <= '0;
         mark_end_q   <= '0;
         ovf_q        <= 16'd0;
         valid_q      <= 1'b0;
         head_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         rdy_q        <= rdy;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pend_last_q  <= pend_last_d;
         mark_start_q <= mark_start_d;
         mark_end_q   <= mark_end_d;
         ovf_q        <= ovf_d;
         valid_q      <= valid_d;
         head_q       <= head_d;
         done_q       <= done_d;
      end
   end

   // Record storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q] <= wdata_s;
   end

   assign res_if.res_valid = valid_q;
   assign res_if.res_start = head_q[REC_W-1 -: POS_W];
   assign res_if.res_end   = head_q[POS_W:1];
   assign res_if.res_last  = head_q[0];
   assign fifo_count       = count_q;
   assign overflow_cnt     = ovf_q;
   assign done             = done_q;

endmodule

// File: tb/tb_regex_match_collector.sv
// Directed bench for regex_match_collector: expected records are queued when stimulus
// is driven and compared against each record the consumer accepts.
module tb_regex_match_collector;
   localparam int POS_W  = 32;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [POS_W-1:0] ONES = {POS_W{1'b1}};

   logic              clk = 1'b0;
   logic              reset_n;
   logic              rdy = 1'b0;
   logic              match = 1'b0;
   logic              last = 1'b0;
   logic [POS_W-1:0]  start_pos = '0;
   logic [POS_W-1:0]  end_pos = '0;
   logic [ADDR_W:0]   fifo_count;
   logic [15:0]       overflow_cnt;
   logic              done;

   regex_match_collector_if #(.POS_W(POS_W)) res_if ();

   regex_match_collector #(.POS_W(POS_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rdy          (rdy),
      .match        (match),
      .last         (last),
      .start_pos    (start_pos),
      .end_pos      (end_pos),
      .res_if       (res_if),
      .fifo_count   (fifo_count),
      .overflow_cnt (overflow_cnt),
      .done         (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [2*POS_W:0] sb [$];
   logic [2*POS_W:0] mon_rec;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [POS_W-1:0] s, input logic [POS_W-1:0] e, input logic l);
      sb.push_back({s, e, l});
   endtask

   task automatic pulse(input logic m, input logic l, input logic [POS_W-1:0] s, input logic [POS_W-1:0] e);
      rdy = 1'b1; match = m; last = l; start_pos = s; end_pos = e;
      tick();
      rdy = 1'b0; match = 1'b0; last = 1'b0;
      tick();
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && done !== 1'b1; i++) tick();
      chk(tag, 64'(done), 64'd1);
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid", 64'(res_if.res_valid), 64'd0);
      chk("rst_last", 64'(res_if.res_last), 64'd0);
      chk("rst_start", 64'(res_if.res_start), 64'd0);
      chk("rst_end", 64'(res_if.res_end), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_ovf", 64'(overflow_cnt), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
   endtask

   // Consumer side: every accepted record must be the oldest expected one.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && res_if.res_valid === 1'b1 && res_if.res_ready === 1'b1) begin
         chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_rec = sb.pop_front();
            chk("res_start", 64'(res_if.res_start), 64'(mon_rec[2*POS_W -: POS_W]));
            chk("res_end", 64'(res_if.res_end), 64'(mon_rec[POS_W:1]));
            chk("res_last", 64'(res_if.res_last), 64'(mon_rec[0]));
         end
      end
   end

   initial begin
      res_if.res_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      chk_reset_vals();
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Basic stream with an empty marker.
      res_if.res_ready = 1'b1;
      push_exp(32'd2, 32'd4, 1'b0);   pulse(1'b1, 1'b0, 32'd2, 32'd4);
      push_exp(32'd5, 32'd9, 1'b0);   pulse(1'b1, 1'b0, 32'd5, 32'd9);
      push_exp(32'd10, 32'd12, 1'b0); pulse(1'b1, 1'b0, 32'd10, 32'd12);
      chk("t1_done_before", 64'(done), 64'd0);
      push_exp(ONES, ONES, 1'b1);     pulse(1'b0, 1'b1, 32'd0, 32'd0);
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);
      chk("t1_count", 64'(fifo_count), 64'd0);

      // Level-held rdy yields one record.
      res_if.res_ready = 1'b0;
      push_exp(32'd3, 32'd7, 1'b0);
      rdy = 1'b1; match = 1'b1; last = 1'b0; start_pos = 32'd3; end_pos = 32'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_count_held", 64'(fifo_count), 64'd1);
      end
      chk("t2_done_cleared", 64'(done), 64'd0);
      rdy = 1'b0; match = 1'b0;
      tick();
      chk("t2_count_after", 64'(fifo_count), 64'd1);
      res_if.res_ready = 1'b1;
      tick();
      chk("t2_count_drained", 64'(fifo_count), 64'd0);
      push_exp(32'd20, 32'd30, 1'b1);
      pulse(1'b1, 1'b1, 32'd20, 32'd30);
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);

      // Overflow with the consumer stalled.
      res_if.res_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < DEPTH) push_exp(32'(i * 16 + 1), 32'(i * 16 + 2), 1'b0);
         pulse(1'b1, 1'b0, 32'(i * 16 + 1), 32'(i * 16 + 2));
      end
      chk("t3_count_full", 64'(fifo_count), 64'd8);
      chk("t3_ovf", 64'(overflow_cnt), 64'd2);

      // Full FIFO: simultaneous pop and match push.
      push_exp(32'd100, 32'd101, 1'b0);
      res_if.res_ready = 1'b1;
      rdy = 1'b1; match = 1'b1; last = 1'b0; start_pos = 32'd100; end_pos = 32'd101;
      tick();
      chk("t4_count_pushpop", 64'(fifo_count), 64'd8);
      chk("t4_ovf", 64'(overflow_cnt), 64'd2);
      res_if.res_ready = 1'b0;
      rdy = 1'b0; match = 1'b0;
      tick();
      chk("t4_count_hold", 64'(fifo_count), 64'd8);

      // Marker while full goes pending; events in DRAIN are ignored.
      push_exp(ONES, ONES, 1'b1);
      pulse(1'b0, 1'b1, 32'd0, 32'd0);
      chk("t3_count_pend", 64'(fifo_count), 64'd8);
      chk("t3_done_pend", 64'(done), 64'd0);
      pulse(1'b1, 1'b0, 32'd7, 32'd7);
      chk("t3_ovf_drain", 64'(overflow_cnt), 64'd2);
      res_if.res_ready = 1'b1;
      wait_done("t3_done", 40);
      chk("t3_sb_empty", 64'(sb.size()), 64'd0);
      chk("t3_count_end", 64'(fifo_count), 64'd0);
      chk("t3_ovf_end", 64'(overflow_cnt), 64'd2);

      // Repeated match reports.
      push_exp(32'd2, 32'd4, 1'b0);
      pulse(1'b1, 1'b0, 32'd2, 32'd4);
`ifndef REGEX_COLLECT_DEDUP_EN
      push_exp(32'd2, 32'd4, 1'b0);
`endif
      pulse(1'b1, 1'b0, 32'd2, 32'd4);
      push_exp(32'd2, 32'd6, 1'b0);
      pulse(1'b1, 1'b0, 32'd2, 32'd6);
      push_exp(ONES, ONES, 1'b1);
      pulse(1'b0, 1'b1, 32'd0, 32'd0);
      wait_done("t5_done", 10);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);
      chk("t5_ovf", 64'(overflow_cnt), 64'd2);

      // Asynchronous reset while draining with four records queued.
      res_if.res_ready = 1'b0;
      pulse(1'b1, 1'b0, 32'd40, 32'd41);
      pulse(1'b1, 1'b0, 32'd42, 32'd43);
      pulse(1'b1, 1'b0, 32'd44, 32'd45);
      pulse(1'b0, 1'b1, 32'd0, 32'd0);
      chk("t6_count_before", 64'(fifo_count), 64'd4);
      reset_n = 1'b0;
      #1;
      chk_reset_vals();
      rdy = 1'b1; match = 1'b1; last = 1'b0; start_pos = 32'd8; end_pos = 32'd9;
      tick();
      reset_n = 1'b1;
      push_exp(32'd8, 32'd9, 1'b0);
      res_if.res_ready = 1'b1;
      tick();
      rdy = 1'b0; match = 1'b0;
      tick();
      push_exp(32'd11, 32'd12, 1'b1);
      pulse(1'b1, 1'b1, 32'd11, 32'd12);
      wait_done("t6_done", 10);
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);
      chk("t6_count_end", 64'(fifo_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
